// File: rtl/cpu_0_oci_mem_sequencer.sv
// OCI debug-memory access sequencer: turns JTAG debug strobes into req/ack accesses
// with address auto-increment and timeout, and reports data and status to the monitor.
module cpu_0_oci_mem_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    input  logic              debugack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam int CNT_W = $clog2(TIMEOUT);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt;
    logic              err_pend;

    logic              any_strobe;
    logic              is_mem;
    logic [ADDR_W-1:0] jdo_addr;
    logic [ADDR_W-1:0] cmd_addr;
    logic              unused_jdo;

    // NOTE: every signal gets a default first so this block can never infer a latch.
    always_comb begin
        any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        jdo_addr   = jdo[ADDR_W+16:17];
        is_mem     = take_action_ocimem_a ? jdo[35] : 1'b1;
        cmd_addr   = take_action_ocimem_a ? jdo_addr : addr;
    end

    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};
    assign busy       = (state != IDLE);

    // NOTE: non-blocking assignments here so every branch reads pre-edge state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            addr          <= '0;
            cnt           <= '0;
            err_pend      <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_strobe) begin
                        monitor_ready <= 1'b0;
                        monitor_error <= 1'b0;
                        cnt           <= '0;
                        err_pend      <= 1'b0;
                        if (take_action_ocimem_a) addr <= jdo_addr;
                        if (is_mem && debugack) begin
                            state     <= ACCESS;
                            mem_req   <= 1'b1;
                            mem_we    <= ~take_action_ocimem_a & take_action_ocimem_b;
                            mem_addr  <= cmd_addr;
                            mem_wdata <= jdo[34:3];
                        end else begin
                            // Plain address load succeeds; a memory command outside debug mode is rejected.
                            state    <= DONE;
                            err_pend <= is_mem;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (any_strobe) err_pend <= 1'b1;
                    if (mem_ack) begin
                        if (!mem_we) MonDReg <= mem_rdata;
                        addr    <= addr + 1'b1;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        mem_req  <= 1'b0;
                        err_pend <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    monitor_ready <= 1'b1;
                    monitor_error <= err_pend | any_strobe;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_0_oci_mem_sequencer.sv
// Bench for cpu_0_oci_mem_sequencer: directed vector table, hand-written corner
// sequences, and randomized commands checked against a transaction-level model.
module tb_cpu_0_oci_mem_sequencer;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic [37:0]       jdo;
    logic              debugack;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;
    logic              busy;

    always #5 clk = ~clk;

    cpu_0_oci_mem_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .take_action_ocimem_a   (take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b   (take_action_ocimem_b),
        .jdo                    (jdo),
        .debugack               (debugack),
        .mem_req                (mem_req),
        .mem_we                 (mem_we),
        .mem_addr               (mem_addr),
        .mem_wdata              (mem_wdata),
        .mem_rdata              (mem_rdata),
        .mem_ack                (mem_ack),
        .MonDReg                (MonDReg),
        .monitor_ready          (monitor_ready),
        .monitor_error          (monitor_error),
        .busy                   (busy)
    );

    typedef struct {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        int                cycles;
        logic [31:0]       mon;
        logic              err;
    } exp_t;

    typedef struct {
        logic              sa, sb, sn;
        logic              rd;
        logic [ADDR_W-1:0] ad;
        logic [31:0]       wd;
        logic              dack;
        int                delay;   // ack after this many req cycles; -1 = never
        logic [31:0]       rdata;
        exp_t              e;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Transaction-level model: current address and last read data
    int          m_addr;
    logic [31:0] m_mon;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] mk_jdo(input logic rd, input logic [ADDR_W-1:0] ad,
                                           input logic [31:0] wd, input logic has_a);
        logic [37:0] j;
        j        = '0;
        j[34:3]  = wd;
        if (has_a) j[ADDR_W+16:17] = ad;
        j[35]    = rd;
        return j;
    endfunction

    function automatic exp_t predict(input logic sa, input logic sb, input logic sn,
                                     input logic [37:0] j, input logic dack,
                                     input int delay, input logic [31:0] rdata);
        exp_t e;
        e = '{req: 1'b0, we: 1'b0, addr: '0, wdata: '0, cycles: 0, mon: m_mon, err: 1'b0};
        if (!(sa || sb || sn)) return e;
        if (sa) begin
            m_addr = int'(j[ADDR_W+16:17]);
            if (!j[35]) return e;
        end
        if (!dack) begin
            e.err = 1'b1;
            return e;
        end
        e.req   = 1'b1;
        e.we    = !sa && sb;
        e.addr  = ADDR_W'(m_addr);
        e.wdata = j[34:3];
        if (delay >= 0 && delay < TIMEOUT) begin
            e.cycles = delay + 1;
            if (!e.we) m_mon = rdata;
            m_addr = (m_addr + 1) % (1 << ADDR_W);
        end else begin
            e.cycles = TIMEOUT;
            e.err    = 1'b1;
        end
        e.mon = m_mon;
        return e;
    endfunction

    // Issue one command from IDLE, act as the memory, and compare the outcome.
    task automatic run_and_check(input string tag, input logic sa, input logic sb, input logic sn,
                                 input logic [37:0] j, input logic dack, input int delay,
                                 input logic [31:0] rdata, input exp_t e);
        logic              saw, we, stable, stop, rdy_mid;
        logic [ADDR_W-1:0] ad;
        logic [31:0]       wd;
        int                cycles;
        @(negedge clk);
        take_action_ocimem_a    = sa;
        take_action_ocimem_b    = sb;
        take_no_action_ocimem_a = sn;
        jdo                     = j;
        debugack                = dack;
        @(negedge clk);
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        rdy_mid = monitor_ready | monitor_error;
        saw = 1'b0; we = 1'b0; ad = '0; wd = '0; cycles = 0; stable = 1'b1; stop = 1'b0;
        for (int g = 0; g < 200 && !stop; g++) begin
            if (mem_req) begin
                if (!saw) begin
                    we = mem_we; ad = mem_addr; wd = mem_wdata; saw = 1'b1;
                end else if (mem_we !== we || mem_addr !== ad || mem_wdata !== wd) begin
                    stable = 1'b0;
                end
                if (cycles == delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
                cycles++;
                @(negedge clk);
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end else if (saw || !busy) begin
                stop = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        for (int g = 0; g < 10 && busy; g++) @(negedge clk);
        check({tag, " status cleared after strobe"}, 64'(rdy_mid), 64'(0));
        check({tag, " req issued"}, 64'(saw), 64'(e.req));
        if (e.req) begin
            check({tag, " mem_we"}, 64'(we), 64'(e.we));
            check({tag, " mem_addr"}, 64'(ad), 64'(e.addr));
            if (e.we) check({tag, " mem_wdata"}, 64'(wd), 64'(e.wdata));
            check({tag, " req cycles"}, 64'(cycles), 64'(e.cycles));
            check({tag, " req fields stable"}, 64'(stable), 64'(1));
        end
        check({tag, " returns idle"}, 64'(busy), 64'(0));
        check({tag, " ready"}, 64'(monitor_ready), 64'(1));
        check({tag, " error"}, 64'(monitor_error), 64'(e.err));
        check({tag, " MonDReg"}, 64'(MonDReg), 64'(e.mon));
    endtask

    vec_t vecs[12];

    initial begin
        exp_t ex;
        logic [37:0] j;

        vecs[0]  = '{1,0,0, 1, 8'h10, 32'h0,        1,  2, 32'hDEADBEEF, '{1,0,8'h10,32'h0,        3, 32'hDEADBEEF,0}};
        vecs[1]  = '{0,0,1, 0, 8'h00, 32'h0,        1,  0, 32'hCAFEF00D, '{1,0,8'h11,32'h0,        1, 32'hCAFEF00D,0}};
        vecs[2]  = '{1,0,0, 0, 8'hFF, 32'h0,        1, -1, 32'h0,        '{0,0,8'h00,32'h0,        0, 32'hCAFEF00D,0}};
        vecs[3]  = '{0,1,0, 0, 8'h00, 32'h12345678, 1,  0, 32'h0,        '{1,1,8'hFF,32'h12345678, 1, 32'hCAFEF00D,0}};
        vecs[4]  = '{0,0,1, 0, 8'h00, 32'h0,        1,  1, 32'h0BADF00D, '{1,0,8'h00,32'h0,        2, 32'h0BADF00D,0}};
        vecs[5]  = '{0,1,0, 0, 8'h00, 32'hA5A5A5A5, 0,  0, 32'h0,        '{0,0,8'h00,32'h0,        0, 32'h0BADF00D,1}};
        vecs[6]  = '{0,1,0, 0, 8'h00, 32'hA5A5A5A5, 1,  3, 32'h0,        '{1,1,8'h01,32'hA5A5A5A5, 4, 32'h0BADF00D,0}};
        vecs[7]  = '{1,1,0, 1, 8'h40, 32'h0,        1,  0, 32'h11112222, '{1,0,8'h40,32'h0,        1, 32'h11112222,0}};
        vecs[8]  = '{0,0,1, 0, 8'h00, 32'h0,        1, 63, 32'h33334444, '{1,0,8'h41,32'h0,       64, 32'h33334444,0}};
        vecs[9]  = '{0,0,1, 0, 8'h00, 32'h0,        1, -1, 32'h99999999, '{1,0,8'h42,32'h0,       64, 32'h33334444,1}};
        vecs[10] = '{0,0,1, 0, 8'h00, 32'h0,        1,  0, 32'h55556666, '{1,0,8'h42,32'h0,        1, 32'h55556666,0}};
        vecs[11] = '{0,0,1, 0, 8'h00, 32'h0,        0,  0, 32'h77777777, '{0,0,8'h00,32'h0,        0, 32'h55556666,1}};

        reset = 1'b1;
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
        jdo = '0; debugack = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        m_addr = 0; m_mon = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset mem_req", 64'(mem_req), 64'(0));
        check("reset outputs", 64'({mem_we, mem_addr, mem_wdata}), 64'(0));
        check("reset MonDReg", 64'(MonDReg), 64'(0));
        check("reset status", 64'({monitor_ready, monitor_error, busy}), 64'(0));

        for (int i = 0; i < 12; i++) begin
            j = mk_jdo(vecs[i].rd, vecs[i].ad, vecs[i].wd, vecs[i].sa);
            ex = predict(vecs[i].sa, vecs[i].sb, vecs[i].sn, j, vecs[i].dack, vecs[i].delay, vecs[i].rdata);
            run_and_check($sformatf("vec%0d", i), vecs[i].sa, vecs[i].sb, vecs[i].sn, j,
                          vecs[i].dack, vecs[i].delay, vecs[i].rdata, vecs[i].e);
        end

        // Overrun: a write strobe during a read ACCESS is dropped and flags an error.
        @(negedge clk);
        take_no_action_ocimem_a = 1'b1; debugack = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b1; jdo = mk_jdo(1'b0, '0, 32'hFFFF0000, 1'b0);
        check("overrun req active", 64'({mem_req, mem_we, mem_addr}), 64'({1'b1, 1'b0, 8'h43}));
        @(negedge clk);
        take_action_ocimem_b = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77778888;
        @(negedge clk);
        mem_ack = 1'b0;
        check("overrun no second req", 64'(mem_req), 64'(0));
        for (int g = 0; g < 10 && busy; g++) @(negedge clk);
        check("overrun status", 64'({monitor_ready, monitor_error}), 64'({1'b1, 1'b1}));
        check("overrun MonDReg", 64'(MonDReg), 64'(32'h77778888));
        repeat (3) @(negedge clk);
        check("overrun stays idle", 64'({mem_req, busy}), 64'(0));
        m_mon = 32'h77778888; m_addr = 8'h44;

        // Reset mid-ACCESS, followed by a late ack that must be ignored.
        @(negedge clk);
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        @(negedge clk);
        check("pre-reset req", 64'(mem_req), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        check("reset mid-access req", 64'(mem_req), 64'(0));
        check("reset mid-access outputs", 64'({mem_we, mem_addr, mem_wdata, busy}), 64'(0));
        check("reset mid-access status", 64'({MonDReg, monitor_ready, monitor_error}), 64'(0));
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBEEFBEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("late ack ignored", 64'({MonDReg, mem_req, busy, monitor_ready}), 64'(0));
        m_addr = 0; m_mon = '0;

        // Randomized commands against the model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] sel;
            logic       dack;
            int         r, delay;
            logic [31:0] rdata;
            sel   = 3'($urandom_range(1, 7));
            j     = {6'($urandom), 32'($urandom)};
            dack  = ($urandom_range(0, 4) != 0);
            r     = $urandom_range(0, 9);
            delay = (r == 0) ? -1 : (r == 1) ? TIMEOUT - 1 : int'($urandom_range(0, 4));
            rdata = $urandom;
            ex = predict(sel[0], sel[1], sel[2], j, dack, delay, rdata);
            run_and_check($sformatf("rand%0d", i), sel[0], sel[1], sel[2], j, dack, delay, rdata, ex);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
